// File: rtl/ssp_xfer_arbiter.sv
// ssp_xfer_arbiter: round-robin sharing of one SSP core among NREQ clients.
// Each granted client gets one full-duplex byte exchange: a write strobe into
// the SSP transmit FIFO, a bounded wait for receive data, a read strobe, then
// a one-cycle done pulse carrying the received byte or a timeout error.
`timescale 1ns/1ps
module ssp_xfer_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic              PCLK,
  input  logic              CLEAR,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] wdata,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic              err,
  output logic [7:0]        rdata,
  output logic              PSEL,
  output logic              PWRITE,
  output logic [7:0]        PWDATA,
  input  logic [7:0]        PRDATA,
  input  logic              SSP_TXFULL,
  input  logic              SSP_RXEMPTY
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  // Counter value whose increment makes it reach TIMEOUT.
  localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [IW-1:0]   IDX_LAST = IW'(NREQ - 1);
  localparam logic [NREQ-1:0] GNT_LSB  = {{(NREQ-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WRITE   = 3'd1,
    ST_WAIT_RX = 3'd2,
    ST_READ    = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  state_t         state_r;
  logic [IW-1:0]  rr_r;
  logic [IW-1:0]  gidx_r;
  logic [CW-1:0]  cnt_r;

  logic           pick_vld_s;
  logic [IW-1:0]  pick_idx_s;
  logic [IW-1:0]  scan_s;

  // Cyclic search for the first requester at or after the rr pointer; scanning
  // from the far end lets the nearest hit overwrite the others.
  always_comb begin
    pick_vld_s = 1'b0;
    pick_idx_s = {IW{1'b0}};
    scan_s     = {IW{1'b0}};
    for (int k = NREQ - 1; k >= 0; k--) begin
      scan_s = IW'((int'(rr_r) + k) % NREQ);
      if (req[scan_s]) begin
        pick_vld_s = 1'b1;
        pick_idx_s = scan_s;
      end else begin
        pick_vld_s = pick_vld_s;
        pick_idx_s = pick_idx_s;
      end
    end
  end

  // Transfer sequencer with all outputs registered; strobes and done default
  // low so each is a single-cycle pulse.
  always_ff @(posedge PCLK) begin
    if (CLEAR) begin
      state_r <= ST_IDLE;
      rr_r    <= {IW{1'b0}};
      gidx_r  <= {IW{1'b0}};
      cnt_r   <= {CW{1'b0}};
      gnt     <= {NREQ{1'b0}};
      done    <= {NREQ{1'b0}};
      err     <= 1'b0;
      rdata   <= 8'h00;
      PSEL    <= 1'b0;
      PWRITE  <= 1'b0;
      PWDATA  <= 8'h00;
    end else begin
      done   <= {NREQ{1'b0}};
      PSEL   <= 1'b0;
      PWRITE <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (pick_vld_s) begin
            gnt     <= GNT_LSB << pick_idx_s;
            gidx_r  <= pick_idx_s;
            PWDATA  <= wdata[8*pick_idx_s +: 8];
            state_r <= ST_WRITE;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_WRITE: begin
          // Transmit FIFO backpressure may stall here indefinitely.
          if (!SSP_TXFULL) begin
            PSEL    <= 1'b1;
            PWRITE  <= 1'b1;
            cnt_r   <= {CW{1'b0}};
            state_r <= ST_WAIT_RX;
          end else begin
            state_r <= ST_WRITE;
          end
        end
        ST_WAIT_RX: begin
          // Receive data is checked first so it wins over a same-cycle timeout.
          if (!SSP_RXEMPTY) begin
            state_r <= ST_READ;
          end else if (cnt_r == CNT_LAST) begin
            cnt_r   <= cnt_r + 1'b1;
            err     <= 1'b1;
            rdata   <= 8'h00;
            state_r <= ST_DONE;
          end else begin
            cnt_r   <= cnt_r + 1'b1;
          end
        end
        ST_READ: begin
          PSEL    <= 1'b1;
          PWRITE  <= 1'b0;
          state_r <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          rdata   <= PRDATA;
          err     <= 1'b0;
          state_r <= ST_DONE;
        end
        ST_DONE: begin
          done    <= GNT_LSB << gidx_r;
          gnt     <= {NREQ{1'b0}};
          rr_r    <= (gidx_r == IDX_LAST) ? {IW{1'b0}} : (gidx_r + 1'b1);
          state_r <= ST_IDLE;
        end
        default: begin
          gnt     <= {NREQ{1'b0}};
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/ssp_xfer_arbiter.md
Name: ssp_xfer_arbiter

Overview:
- Shares one SSP core among NREQ client requesters.
- Each client asks for a full-duplex byte exchange: one byte written into the SSP transmit FIFO, one byte read back from the SSP receive FIFO.
- Arbitration is round-robin. The block owns the SSP APB-side strobes (PSEL/PWRITE/PWDATA), sequences write, wait and read, and returns the received byte, or a timeout error, to the granted client.

Parameters:
- NREQ, 4, number of requester channels (2..8)
- TIMEOUT, 1023, max PCLK cycles spent waiting for receive data before aborting (fits in 10-bit counter)

Ports:
- PCLK  in  1  single clock for all logic
- CLEAR  in  1  synchronous, active-high reset
- req  in  NREQ  per-client request level; held high until that client's done pulse
- wdata  in  8*NREQ  per-client transmit byte, client i at [8i+7:8i]; stable while req[i] is high
- gnt  out  NREQ  one-hot grant; high from arbitration until done
- done  out  NREQ  one-cycle completion pulse to the granted client
- err  out  1  valid with done; 1 = receive timeout
- rdata  out  8  received byte; valid when done is high, held until the next done
- PSEL  out  1  SSP select strobe
- PWRITE  out  1  SSP write enable (meaningful only with PSEL)
- PWDATA  out  8  byte to SSP transmit FIFO
- PRDATA  in  8  SSP receive FIFO read data
- SSP_TXFULL  in  1  SSP transmit FIFO full
- SSP_RXEMPTY  in  1  SSP receive FIFO empty

Behaviour:
- Reset (CLEAR high at a PCLK edge) forces the following: state IDLE, gnt=0, done=0, err=0, rdata=0, PSEL=0, PWRITE=0, PWDATA=0, rr pointer=0, timeout counter=0.
- Reset mid-transfer aborts the transfer with no done pulse; the client must re-request.
- All outputs are registered.
- States: IDLE, WRITE, WAIT_RX, READ, CAPTURE, DONE.
- IDLE:
  - If any req bit is high, pick the first requester at or after rr pointer (cyclic search).
  - Set the gnt bit, latch its wdata into PWDATA, go to WRITE.
  - No req: stay in IDLE.
- WRITE:
  - If SSP_TXFULL=0, drive PSEL=1, PWRITE=1 for exactly one cycle, then go to WAIT_RX with the timeout counter cleared.
  - If SSP_TXFULL=1, hold PSEL=0 and stay in WRITE indefinitely; no timeout applies here.
- WAIT_RX:
  - If SSP_RXEMPTY=0, go to READ.
  - Else increment the counter. On counter==TIMEOUT, go to DONE with err=1 and rdata=0.
  - SSP_RXEMPTY dropping in the same cycle the counter reaches TIMEOUT: data wins, go to READ.
- READ: PSEL=1, PWRITE=0 for exactly one cycle, then go to CAPTURE.
- CAPTURE: sample PRDATA into rdata (the value present in the cycle after the read strobe), err=0, go to DONE.
- DONE:
  - Pulse done[granted]=1 for one cycle.
  - Clear gnt.
  - Set rr pointer = granted index + 1, wrapping NREQ-1 to 0.
  - Return to IDLE.
- Grant cadence: minimum back-to-back transfer is 5 cycles from the grant edge to done (WRITE, WAIT_RX, READ, CAPTURE, DONE) when FIFOs are ready. A new grant may assert the cycle after DONE.
- PSEL is never high outside WRITE or READ; at most one PSEL cycle per state visit.
- gnt is one-hot or zero at all times.
- A client dropping req after being granted does not cancel the transfer; it completes normally.
- req bits of non-granted clients are ignored until IDLE.
- Fairness: with all req high, grant order is 0,1,...,NREQ-1,0...

Test Plan:
- Single request: req=0001, wdata0=8'hA5, FIFOs ready, PRDATA=8'h3C after read strobe -> one PSEL&PWRITE cycle with PWDATA=A5, one PSEL&!PWRITE cycle, done[0] pulse 5 cycles after gnt[0], rdata=3C, err=0.
- Round robin: req=1111 held, each byte distinct -> grants in order 0,1,2,3,0; each PWDATA matches the granted client's byte; no gnt overlap.
- TX backpressure: SSP_TXFULL=1 for 20 cycles after grant -> PSEL stays 0 for those cycles; write occurs the cycle after TXFULL falls; no timeout.
- RX timeout (TIMEOUT=15 override): SSP_RXEMPTY stuck 1 -> done pulse with err=1, rdata=00, no read strobe issued; next requester then granted.
- Simultaneous edge: RXEMPTY falls on the cycle the counter hits TIMEOUT -> read strobe issued, err=0, rdata=PRDATA.
- Reset mid-transfer: assert CLEAR during WAIT_RX -> next cycle all outputs zero, no done pulse; rr pointer=0 so client 0 is granted first afterwards.
